// File: rtl/am_slot_scheduler.sv
// rtl/am_slot_scheduler.sv - AM/data slot sequencer for the per-flow 257-bit block stream
module am_slot_scheduler #(
   parameter int AM_PERIOD_BLOCKS = 1024,
   parameter int AM_BLOCKS        = 40,
   parameter int FRAME_CNT_W      = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_enable,
   input  logic                         i_ready,
   input  logic                         i_src_valid,
   output logic                         o_src_pop,
   output logic                         o_slot_valid,
   output logic                         o_slot_is_am,
   output logic [$clog2(AM_BLOCKS):0]   o_am_idx,
   output logic                         o_frame_start,
   output logic                         o_underflow,
   output logic [FRAME_CNT_W-1:0]       o_frame_cnt,
   output logic [1:0]                   o_state
);

   localparam int MAX_BLK = (AM_BLOCKS > AM_PERIOD_BLOCKS) ? AM_BLOCKS : AM_PERIOD_BLOCKS;
   localparam int CNT_W   = $clog2(MAX_BLK) + 1;
   localparam int IDX_W   = $clog2(AM_BLOCKS) + 1;

   localparam logic [CNT_W-1:0] LAST_AM   = CNT_W'(AM_BLOCKS - 1);
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(AM_PERIOD_BLOCKS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_AM   = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic                   underflow_q, underflow_d;
   logic                   slot_valid_q, slot_valid_d;
   logic                   slot_is_am_q, slot_is_am_d;
   logic [IDX_W-1:0]       am_idx_q, am_idx_d;
   logic                   frame_start_q, frame_start_d;
   logic                   adv;

   // Next-state logic: slot advance, counter/frame sequencing and the slot descriptor for next cycle
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      frame_cnt_d = frame_cnt_q;
      underflow_d = underflow_q;
      adv         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_enable) begin
               state_d = S_AM;
               cnt_d   = '0;
            end
         end
         S_AM: begin
            // An AM group always runs to completion; i_enable is not looked at here
            adv = i_ready;
            if (adv) begin
               if (cnt_q == LAST_AM) begin
                  state_d = S_DATA;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_DATA: begin
            adv = i_ready & i_src_valid;
            // Downstream wanted a data block but the source had none: no filler, just flag it
            if (i_ready & ~i_src_valid) begin
               underflow_d = 1'b1;
            end
            if (adv) begin
               if (cnt_q == LAST_DATA) begin
                  frame_cnt_d = frame_cnt_q + 1'b1;
                  cnt_d       = '0;
                  state_d     = i_enable ? S_AM : S_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      slot_valid_d  = adv;
      slot_is_am_d  = adv & (state_q == S_AM);
      am_idx_d      = slot_is_am_d ? IDX_W'(cnt_q) : '0;
      frame_start_d = slot_is_am_d & (cnt_q == '0);
   end

   // State, counters and registered slot outputs; reset aborts any partial frame
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         frame_cnt_q   <= '0;
         underflow_q   <= 1'b0;
         slot_valid_q  <= 1'b0;
         slot_is_am_q  <= 1'b0;
         am_idx_q      <= '0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         frame_cnt_q   <= frame_cnt_d;
         underflow_q   <= underflow_d;
         slot_valid_q  <= slot_valid_d;
         slot_is_am_q  <= slot_is_am_d;
         am_idx_q      <= am_idx_d;
         frame_start_q <= frame_start_d;
      end
   end

   // Pop is combinational so the source sees it in the same cycle the block is taken
   assign o_src_pop     = (state_q == S_DATA) & i_ready & i_src_valid & ~rst;
   assign o_slot_valid  = slot_valid_q;
   assign o_slot_is_am  = slot_is_am_q;
   assign o_am_idx      = am_idx_q;
   assign o_frame_start = frame_start_q;
   assign o_underflow   = underflow_q;
   assign o_frame_cnt   = frame_cnt_q;
   assign o_state       = state_q;

endmodule

// File: tb/tb_am_slot_scheduler.sv
// tb/tb_am_slot_scheduler.sv - randomized and directed bench for am_slot_scheduler
module tb_am_slot_scheduler;

   localparam int APB = 4;
   localparam int AMB = 2;
   localparam int FCW = 2;
   localparam int FRAME_LEN = AMB + APB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic i_enable = 1'b0;
   logic i_ready = 1'b0;
   logic i_src_valid = 1'b0;
   logic o_src_pop;
   logic o_slot_valid;
   logic o_slot_is_am;
   logic [$clog2(AMB):0] o_am_idx;
   logic o_frame_start;
   logic o_underflow;
   logic [FCW-1:0] o_frame_cnt;
   logic [1:0] o_state;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: running flag plus position within the frame (0..FRAME_LEN-1)
   bit m_run = 0;
   int m_pos = 0;
   int m_fcnt = 0;
   bit m_uf = 0;
   bit m_sv = 0, m_am = 0, m_fs = 0;
   int m_idx = 0;

   am_slot_scheduler #(
      .AM_PERIOD_BLOCKS(APB),
      .AM_BLOCKS(AMB),
      .FRAME_CNT_W(FCW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .i_enable(i_enable),
      .i_ready(i_ready),
      .i_src_valid(i_src_valid),
      .o_src_pop(o_src_pop),
      .o_slot_valid(o_slot_valid),
      .o_slot_is_am(o_slot_is_am),
      .o_am_idx(o_am_idx),
      .o_frame_start(o_frame_start),
      .o_underflow(o_underflow),
      .o_frame_cnt(o_frame_cnt),
      .o_state(o_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_state();
      if (!m_run) return 0;
      return (m_pos < AMB) ? 1 : 2;
   endfunction

   // One clock: drive inputs, check pop, advance the model, check registered outputs
   task automatic step(input bit r, input bit en, input bit rdy, input bit sv);
      bit adv, in_am;
      rst = r; i_enable = en; i_ready = rdy; i_src_valid = sv;
      #1;
      in_am = m_run && (m_pos < AMB);
      check("src_pop", o_src_pop, !r && m_run && !in_am && rdy && sv);
      if (r) begin
         m_run = 0; m_pos = 0; m_fcnt = 0; m_uf = 0;
         m_sv = 0; m_am = 0; m_idx = 0; m_fs = 0;
      end else if (!m_run) begin
         m_sv = 0; m_am = 0; m_idx = 0; m_fs = 0;
         if (en) begin m_run = 1; m_pos = 0; end
      end else begin
         adv = rdy && (in_am || sv);
         if (!in_am && rdy && !sv) m_uf = 1;
         m_sv = adv;
         m_am = adv && in_am;
         m_idx = m_am ? m_pos : 0;
         m_fs = m_am && (m_pos == 0);
         if (adv) begin
            m_pos++;
            if (m_pos == FRAME_LEN) begin
               m_pos = 0;
               m_fcnt = (m_fcnt + 1) % (1 << FCW);
               m_run = en;
            end
         end
      end
      @(posedge clk);
      #1;
      check("slot_valid", o_slot_valid, m_sv);
      check("slot_is_am", o_slot_is_am, m_am);
      check("am_idx", o_am_idx, m_idx);
      check("frame_start", o_frame_start, m_fs);
      check("underflow", o_underflow, m_uf);
      check("frame_cnt", o_frame_cnt, m_fcnt);
      check("state", o_state, exp_state());
      @(negedge clk);
   endtask

   // Run with full flow until the model reaches frame position k (bounded)
   task automatic run_to(input int k);
      bit hit = 0;
      for (int i = 0; i < 3 * FRAME_LEN; i++) begin
         if (m_run && m_pos == k) begin hit = 1; break; end
         step(0, 1, 1, 1);
      end
      check("run_to_reached", hit, 1);
   endtask

   initial begin
      @(negedge clk);
      // Reset for two cycles
      step(1, 0, 0, 0);
      step(1, 1, 1, 1);
      check("rst_state", o_state, 0);
      check("rst_fcnt", o_frame_cnt, 0);

      // Continuous run: idle->AM cycle then 18 slots
      for (int i = 0; i < 1 + 3 * FRAME_LEN; i++) step(0, 1, 1, 1);
      check("fcnt_after_18", o_frame_cnt, 3);

      // Backpressure inside AM group and inside data slots
      run_to(1);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 1);
      run_to(AMB + 1);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 1);
      run_to(0);
      check("no_uf_after_bp", o_underflow, 0);

      // Underflow at data slot 2
      run_to(AMB + 2);
      step(0, 1, 1, 0);
      step(0, 1, 1, 0);
      check("uf_set", o_underflow, 1);
      run_to(0);

      // Stop at boundary, then re-enable
      run_to(AMB + 1);
      for (int i = 0; i < 6; i++) step(0, 0, 1, 1);
      check("stopped_idle", o_state, 0);
      step(0, 1, 1, 1);
      step(0, 1, 1, 1);
      check("reenable_fs", o_frame_start, 1);

      // Reset mid-frame
      run_to(AMB + 2);
      step(1, 1, 1, 1);
      check("midrst_fcnt", o_frame_cnt, 0);
      check("midrst_uf", o_underflow, 0);

      // Frame counter wrap over 5 frames
      step(0, 1, 1, 1);
      for (int f = 0; f < 5; f++)
         for (int i = 0; i < FRAME_LEN; i++) step(0, 1, 1, 1);
      check("wrap_fcnt", o_frame_cnt, 1);

      // Randomized traffic with occasional reset
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
